// File: rtl/padctrl_attr_pkg.sv
// Shared constants for the pad attribute register block: sizes, register map, byte permits, bus FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package padctrl_attr_pkg;

    localparam int NMioPads   = 32;
    localparam int NDioPads   = 15;
    localparam int AttrDw     = 10;
    localparam int NumRegs    = 17;
    localparam int PadsPerReg = 3;

    localparam int RegenIdx     = 0;
    localparam int DioPads0Idx  = 1;
    localparam int MioPads0Idx  = 6;
    localparam int MioPads10Idx = 16;

    localparam logic [6:0] REG_OFFSET [NumRegs] = '{
        7'h00,
        7'h04, 7'h08, 7'h0C, 7'h10, 7'h14,
        7'h18, 7'h1C, 7'h20, 7'h24, 7'h28, 7'h2C,
        7'h30, 7'h34, 7'h38, 7'h3C, 7'h40
    };

    localparam logic [3:0] PERMIT [NumRegs] = '{
        4'b0001,
        4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
        4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
        4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111
    };

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/padctrl_bus_if.sv
// Single-outstanding req/gnt/rvalid handshake with captured response data and error flag.
// Response one cycle after grant; no grant while a response waits for rready.
module padctrl_bus_if
    import padctrl_attr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rready,
    input  logic [31:0] resp_rdata,
    input  logic        resp_err,
    output logic        gnt,
    output logic        accept,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    bus_state_e  state_q;
    bus_state_e  state_d;
    logic [31:0] rdata_q;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rdata_q <= resp_rdata;
                err_q   <= resp_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        accept  = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt    = !rst;
                accept = req && !rst;
                if (accept) state_d = RESP;
            end
            RESP: begin
                rvalid = 1'b1;
                if (rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: rtl/padctrl_attr_regs.sv
// Register-mapped MIO/DIO pad attributes with WARL masking and a sticky write-0-to-clear lock.
// Attribute outputs update on the accepting edge; one access in flight, held until rready.
module padctrl_attr_regs #(
    parameter int                                        NMioPads = padctrl_attr_pkg::NMioPads,
    parameter int                                        NDioPads = padctrl_attr_pkg::NDioPads,
    parameter int                                        AttrDw   = padctrl_attr_pkg::AttrDw,
    parameter logic [AttrDw-1:0]                         WarlMask = '1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic                         we_i,
    input  logic [6:0]                   addr_i,
    input  logic [31:0]                  wdata_i,
    input  logic [3:0]                   be_i,
    output logic                         gnt_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [31:0]                  rdata_o,
    output logic                         err_o,
    output logic [NMioPads*AttrDw-1:0]   mio_attr_o,
    output logic [NDioPads*AttrDw-1:0]   dio_attr_o
);
    import padctrl_attr_pkg::*;

    logic              regen_q;
    logic [AttrDw-1:0] mio_q [NMioPads];
    logic [AttrDw-1:0] dio_q [NDioPads];

    logic        hit;
    logic [4:0]  hit_idx;
    logic [3:0]  permit;
    logic        acc_err;
    logic        accept;
    logic        wr_en;
    logic [31:0] rd_word;
    logic [31:0] resp_rdata;

    // Exact offset match also rejects misaligned and out-of-range addresses.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int r = 0; r < NumRegs; r++) begin
            if (addr_i == REG_OFFSET[r]) begin
                hit     = 1'b1;
                hit_idx = 5'(r);
            end
        end
    end

    assign permit  = PERMIT[hit_idx];
    assign acc_err = !hit || (we_i && ((be_i & permit) != permit));
    assign wr_en   = accept && we_i && !acc_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regen_q <= 1'b1;
            for (int k = 0; k < NMioPads; k++) mio_q[k] <= '0;
            for (int k = 0; k < NDioPads; k++) dio_q[k] <= '0;
        end else if (wr_en) begin
            if (hit_idx == 5'(RegenIdx) && !wdata_i[0]) regen_q <= 1'b0;
            if (regen_q) begin
                for (int k = 0; k < NMioPads; k++) begin
                    if (hit_idx == 5'(MioPads0Idx + k / PadsPerReg))
                        mio_q[k] <= wdata_i[(k % PadsPerReg)*AttrDw +: AttrDw] & WarlMask;
                end
                for (int k = 0; k < NDioPads; k++) begin
                    if (hit_idx == 5'(DioPads0Idx + k / PadsPerReg))
                        dio_q[k] <= wdata_i[(k % PadsPerReg)*AttrDw +: AttrDw] & WarlMask;
                end
            end
        end
    end

    // Unbacked field positions (bits 31:30, and MIO_PADS10 above pad 31) fall out as zero.
    always_comb begin
        rd_word = '0;
        if (hit_idx == 5'(RegenIdx)) rd_word[0] = regen_q;
        for (int k = 0; k < NMioPads; k++) begin
            if (hit_idx == 5'(MioPads0Idx + k / PadsPerReg))
                rd_word[(k % PadsPerReg)*AttrDw +: AttrDw] = mio_q[k];
        end
        for (int k = 0; k < NDioPads; k++) begin
            if (hit_idx == 5'(DioPads0Idx + k / PadsPerReg))
                rd_word[(k % PadsPerReg)*AttrDw +: AttrDw] = dio_q[k];
        end
    end

    assign resp_rdata = (acc_err || we_i) ? 32'd0 : rd_word;

    for (genvar k = 0; k < NMioPads; k++) begin : g_mio_out
        assign mio_attr_o[k*AttrDw +: AttrDw] = mio_q[k];
    end
    for (genvar k = 0; k < NDioPads; k++) begin : g_dio_out
        assign dio_attr_o[k*AttrDw +: AttrDw] = dio_q[k];
    end

    logic unused_wdata;
    assign unused_wdata = ^wdata_i[31:30];

    padctrl_bus_if u_bus_if (
        .clk        (clk_i),
        .rst        (rst_i),
        .req        (req_i),
        .rready     (rready_i),
        .resp_rdata (resp_rdata),
        .resp_err   (acc_err),
        .gnt        (gnt_o),
        .accept     (accept),
        .rvalid     (rvalid_o),
        .rdata      (rdata_o),
        .err        (err_o)
    );

endmodule

// File: tb/tb_padctrl_attr_regs.sv
// Directed bench for padctrl_attr_regs: a full-mask instance and a 10'h00F-mask instance share one bus.
module tb_padctrl_attr_regs;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [6:0]   addr_i;
    logic [31:0]  wdata_i;
    logic [3:0]   be_i;
    logic         rready_i;

    logic         gnt_o, rvalid_o, err_o;
    logic [31:0]  rdata_o;
    logic [319:0] mio_attr_o;
    logic [149:0] dio_attr_o;

    logic         gnt_m, rvalid_m, err_m;
    logic [31:0]  rdata_m;
    logic [319:0] mio_attr_m;
    logic [149:0] dio_attr_m;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd, rdm;
    logic        er;

    always #5 clk_i = ~clk_i;

    padctrl_attr_regs dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o),
        .mio_attr_o(mio_attr_o), .dio_attr_o(dio_attr_o)
    );

    padctrl_attr_regs #(.WarlMask(10'h00F)) dut_m (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_m), .rvalid_o(rvalid_m),
        .rready_i(rready_i), .rdata_o(rdata_m), .err_o(err_m),
        .mio_attr_o(mio_attr_m), .dio_attr_o(dio_attr_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one access; returns at the falling edge of the response cycle.
    task automatic access(input logic we, input logic [6:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdat, output logic rerr,
                          output logic [31:0] rdat_m);
        int n;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
        n = 0;
        while (!gnt_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) check("gnt_timeout", {31'd0, gnt_o}, 32'd1);
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        check("rvalid", {31'd0, rvalid_o}, 32'd1);
        rdat = rdata_o; rerr = err_o; rdat_m = rdata_m;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        rready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", {31'd0, gnt_o}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_mio", {31'd0, |mio_attr_o}, 32'd0);
        check("rst_dio", {31'd0, |dio_attr_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_gnt", {31'd0, gnt_o}, 32'd1);

        access(1'b0, 7'h24, 32'h0, 4'h0, rd, er, rdm);
        check("rd_mio3", rd, 32'd0);
        check("rd_mio3_err", {31'd0, er}, 32'd0);
        access(1'b0, 7'h00, 32'h0, 4'h0, rd, er, rdm);
        check("rd_regen_rst", rd, 32'd1);

        access(1'b1, 7'h08, 32'h2AB5_5155, 4'hF, rd, er, rdm);
        check("wr_dio1_err", {31'd0, er}, 32'd0);
        check("wr_dio1_rdata", rd, 32'd0);
        check("dio_pad3", dio_attr_o[30 +: 10], 32'h155);
        check("dio_pad4", dio_attr_o[40 +: 10], 32'h154);
        check("dio_pad5", dio_attr_o[50 +: 10], 32'h2AB);
        access(1'b0, 7'h08, 32'h0, 4'h0, rd, er, rdm);
        check("rb_dio1", rd, 32'h2AB5_5155);

        access(1'b1, 7'h18, 32'h0000_03FF, 4'hF, rd, er, rdm);
        check("mio0_full", mio_attr_o[9:0], 32'h3FF);
        check("mio0_mask", mio_attr_m[9:0], 32'h00F);
        access(1'b0, 7'h18, 32'h0, 4'h0, rd, er, rdm);
        check("rb_mio0_mask", rdm[9:0], 32'h00F);

        access(1'b1, 7'h40, 32'hFFFF_FFFF, 4'b0011, rd, er, rdm);
        check("mio10_be_err", {31'd0, er}, 32'd1);
        check("mio10_nochg", mio_attr_o[300 +: 20], 32'd0);
        access(1'b1, 7'h40, 32'hFFFF_FFFF, 4'b0111, rd, er, rdm);
        check("mio10_ok_err", {31'd0, er}, 32'd0);
        check("mio_pad30", mio_attr_o[300 +: 10], 32'h3FF);
        check("mio_pad31", mio_attr_o[310 +: 10], 32'h3FF);
        access(1'b0, 7'h40, 32'h0, 4'h0, rd, er, rdm);
        check("rb_mio10", rd, 32'h000F_FFFF);
        check("rb_mio10_mask", rdm, 32'h0000_3C0F);

        access(1'b1, 7'h20, 32'hFFFF_FFFF, 4'hF, rd, er, rdm);
        check("mio_pad6_8", mio_attr_o[60 +: 30], 32'h3FFF_FFFF);
        access(1'b0, 7'h20, 32'h0, 4'h0, rd, er, rdm);
        check("rb_mio2_hi0", rd, 32'h3FFF_FFFF);

        access(1'b0, 7'h44, 32'h0, 4'h0, rd, er, rdm);
        check("rd_44_err", {31'd0, er}, 32'd1);
        check("rd_44_rdata", rd, 32'd0);
        access(1'b0, 7'h05, 32'h0, 4'h0, rd, er, rdm);
        check("rd_05_err", {31'd0, er}, 32'd1);
        check("rd_05_rdata", rd, 32'd0);
        access(1'b1, 7'h1A, 32'hFFFF_FFFF, 4'hF, rd, er, rdm);
        check("wr_1a_err", {31'd0, er}, 32'd1);
        check("wr_1a_nochg", mio_attr_o[10 +: 20], 32'd0);

        access(1'b1, 7'h00, 32'h0, 4'h0, rd, er, rdm);
        check("regen_be0_err", {31'd0, er}, 32'd1);
        access(1'b0, 7'h00, 32'h0, 4'h0, rd, er, rdm);
        check("regen_still1", rd, 32'd1);
        access(1'b1, 7'h00, 32'h0, 4'b0001, rd, er, rdm);
        check("regen_clr_err", {31'd0, er}, 32'd0);
        access(1'b1, 7'h04, 32'hFFFF_FFFF, 4'hF, rd, er, rdm);
        check("locked_wr_err", {31'd0, er}, 32'd0);
        check("locked_dio0_2", dio_attr_o[0 +: 30], 32'd0);
        access(1'b1, 7'h00, 32'h1, 4'hF, rd, er, rdm);
        access(1'b0, 7'h00, 32'h0, 4'h0, rd, er, rdm);
        check("regen_sticky", rd, 32'd0);
        access(1'b0, 7'h08, 32'h0, 4'h0, rd, er, rdm);
        check("locked_rb_dio1", rd, 32'h2AB5_5155);

        // Response held under rready=0 with a competing request pending.
        @(negedge clk_i);
        rready_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 7'h08; be_i = 4'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            check("hold_gnt", {31'd0, gnt_o}, 32'd0);
            check("hold_rvalid", {31'd0, rvalid_o}, 32'd1);
            check("hold_rdata", rdata_o, 32'h2AB5_5155);
            @(negedge clk_i);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_hold_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_hold_gnt", {31'd0, gnt_o}, 32'd0);
        check("rst_hold_dio", {31'd0, |dio_attr_o}, 32'd0);
        rst_i = 1'b0; req_i = 1'b0; rready_i = 1'b1;

        access(1'b0, 7'h00, 32'h0, 4'h0, rd, er, rdm);
        check("regen_after_rst", rd, 32'd1);
        access(1'b0, 7'h08, 32'h0, 4'h0, rd, er, rdm);
        check("dio1_after_rst", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
